cdc_event_accum: RTL and testbench

- Destination-domain consumer of the single-cycle pulses produced by the pulse-handshake synchronizer (clkB side).
- Counts received event pulses into batches.
- Flushes each batch as a count word on a valid/ready interface, either when the batch reaches a threshold or when a timeout expires.
- Never drops an event while the output is back-pressured, except when the counter saturates, which is flagged.

---
 rtl/cdc_event_accum.sv | 143 ++++++++++++++
 tb/tb_cdc_event_accum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_event_accum.sv
// Destination-domain event batcher: counts sync'd pulses and emits
// count words on valid/ready when a batch fills or times out.
module cdc_event_accum #(
  parameter int CNT_W   = 8,
  parameter int BATCH   = 16,
  parameter int TIMEOUT = 64,
  localparam int TO_W   = $clog2(TIMEOUT)
) (
  input  logic             clkB,
  input  logic             rstB_n,
  input  logic             evt_i,
  input  logic             clr_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_reason,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] BATCH_V = CNT_W'(BATCH);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsn_q, rsn_d;
  logic             oovf_q, oovf_d;

  logic [CNT_W-1:0] acc_add;
  logic             ovf_add;
  logic             full;
  logic             tmo;
  logic             hs;

  // Saturating accumulate; a lost event marks the batch sticky-overflowed
  always_comb begin
    acc_add = acc_q;
    ovf_add = ovf_q;
    if (evt_i) begin
      if (acc_q == ACC_MAX) begin
        ovf_add = 1'b1;
      end else begin
        acc_add = acc_q + 1'b1;
      end
    end
  end

  assign full = (acc_q >= BATCH_V);
  assign tmo  = (timer_q == TO_LAST);
  assign hs   = (state_q == OUTPUT) && out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    rsn_d   = rsn_q;
    oovf_d  = oovf_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      timer_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (evt_i) begin
            state_d = ACCUM;
            acc_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            timer_d = '0;
          end
        end
        ACCUM: begin
          if (full || tmo) begin
            // Flush uses pre-event values; this cycle's event opens the next batch
            state_d = OUTPUT;
            cnt_d   = acc_q;
            oovf_d  = ovf_q;
            rsn_d   = full;
            acc_d   = {{(CNT_W-1){1'b0}}, evt_i};
            ovf_d   = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
            acc_d   = acc_add;
            ovf_d   = ovf_add;
          end
        end
        OUTPUT: begin
          acc_d = acc_add;
          ovf_d = ovf_add;
          if (hs) begin
            timer_d = '0;
            state_d = (acc_add != '0) ? ACCUM : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          timer_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rsn_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rsn_q   <= rsn_d;
      oovf_q  <= oovf_d;
    end
  end

  assign out_valid  = (state_q == OUTPUT);
  assign out_count  = cnt_q;
  assign out_reason = rsn_q;
  assign out_ovf    = oovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_event_accum.sv
// Directed bench for cdc_event_accum: timeout, threshold,
// back-pressure, saturation, clear and reset scenarios.
module tb_cdc_event_accum;

  logic       clkB = 1'b0;
  logic       rstB_n;
  logic       evt_i;
  logic       clr_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_count;
  logic       out_reason;
  logic       out_ovf;
  logic       busy;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clkB = ~clkB;

  cdc_event_accum #(
    .CNT_W  (8),
    .BATCH  (16),
    .TIMEOUT(64)
  ) dut (
    .clkB      (clkB),
    .rstB_n    (rstB_n),
    .evt_i     (evt_i),
    .clr_i     (clr_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_reason(out_reason),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int seen;
    int moved;
    rstB_n    = 1'b0;
    evt_i     = 1'b0;
    clr_i     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_count", 32'(out_count), 0);
    tick();
    rstB_n = 1'b1;
    tick();

    // single timeout batch
    evt_i = 1'b1;
    out_ready = 1'b1;
    tick();
    evt_i = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    ticks(63);
    chk("t1_early", 32'(out_valid), 0);
    tick();
    chk("t1_valid",  32'(out_valid), 1);
    chk("t1_count",  32'(out_count), 1);
    chk("t1_reason", 32'(out_reason), 0);
    chk("t1_ovf",    32'(out_ovf), 0);
    tick();
    chk("t1_once", 32'(out_valid), 0);
    chk("t1_idle", 32'(busy), 0);

    // threshold batch, 17th event spills into next batch
    evt_i = 1'b1;
    ticks(16);
    chk("t2_early", 32'(out_valid), 0);
    tick();
    evt_i = 1'b0;
    chk("t2_valid",  32'(out_valid), 1);
    chk("t2_count",  32'(out_count), 16);
    chk("t2_reason", 32'(out_reason), 1);
    tick();
    chk("t2_hs",   32'(out_valid), 0);
    chk("t2_busy", 32'(busy), 1);
    ticks(63);
    chk("t2_to_early", 32'(out_valid), 0);
    tick();
    chk("t2_to_valid",  32'(out_valid), 1);
    chk("t2_to_count",  32'(out_count), 1);
    chk("t2_to_reason", 32'(out_reason), 0);
    tick();
    chk("t2_idle", 32'(busy), 0);

    // back-pressure
    out_ready = 1'b0;
    evt_i = 1'b1;
    ticks(16);
    evt_i = 1'b0;
    tick();
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_count", 32'(out_count), 16);
    moved = 0;
    for (int i = 0; i < 40; i++) begin
      evt_i = (i % 4 == 0);
      tick();
      if (!out_valid || out_count != 8'd16) moved++;
    end
    evt_i = 1'b0;
    chk("t3_stable", 32'(moved), 0);
    out_ready = 1'b1;
    tick();
    chk("t3_hs",    32'(out_valid), 0);
    chk("t3_accum", 32'(busy), 1);
    ticks(63);
    chk("t3_early", 32'(out_valid), 0);
    tick();
    chk("t3_valid2",  32'(out_valid), 1);
    chk("t3_count2",  32'(out_count), 10);
    chk("t3_reason2", 32'(out_reason), 0);
    tick();
    chk("t3_idle", 32'(busy), 0);

    // saturation while back-pressured
    out_ready = 1'b0;
    evt_i = 1'b1;
    ticks(16);
    evt_i = 1'b0;
    tick();
    chk("t4_first", 32'(out_count), 16);
    chk("t4_ovf0",  32'(out_ovf), 0);
    evt_i = 1'b1;
    ticks(300);
    evt_i = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_hs", 32'(out_valid), 0);
    tick();
    chk("t4_valid",  32'(out_valid), 1);
    chk("t4_count",  32'(out_count), 255);
    chk("t4_ovf",    32'(out_ovf), 1);
    chk("t4_reason", 32'(out_reason), 1);
    tick();
    chk("t4_idle", 32'(busy), 0);

    // clear during OUTPUT with simultaneous event
    out_ready = 1'b0;
    evt_i = 1'b1;
    ticks(16);
    evt_i = 1'b0;
    tick();
    chk("t5_pend", 32'(out_valid), 1);
    evt_i = 1'b1;
    clr_i = 1'b1;
    tick();
    evt_i = 1'b0;
    clr_i = 1'b0;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_busy",  32'(busy), 0);
    out_ready = 1'b1;
    ticks(70);
    chk("t5_quiet", 32'(busy | out_valid), 0);

    // reset mid-ACCUM
    evt_i = 1'b1;
    ticks(5);
    evt_i = 1'b0;
    ticks(3);
    chk("t6_accum", 32'(busy), 1);
    #2;
    rstB_n = 1'b0;
    #1;
    chk("t6_valid",  32'(out_valid), 0);
    chk("t6_busy",   32'(busy), 0);
    chk("t6_count",  32'(out_count), 0);
    chk("t6_reason", 32'(out_reason), 0);
    chk("t6_ovf",    32'(out_ovf), 0);
    tick();
    rstB_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("t6_noword", 32'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
